// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL mode switcher: reconfig controller register map,
// default fractional-M values and the sequencing FSM states.
package pll_cfg_pkg;

    localparam logic [5:0] REG_MODE  = 6'h00;
    localparam logic [5:0] REG_START = 6'h02;
    localparam logic [5:0] REG_MFRAC = 6'h07;

    localparam logic [31:0] K_NTSC_DEF = 32'd2537930535;
    localparam logic [31:0] K_PAL_DEF  = 32'd2201376210;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_LOCK,
        ST_WR_MODE,
        ST_WR_K,
        ST_WR_START,
        ST_WAIT_UNLOCK,
        ST_WAIT_RELOCK
    } state_t;

    function automatic logic is_wait(input state_t s);
        return (s == ST_WAIT_LOCK) || (s == ST_WAIT_UNLOCK) || (s == ST_WAIT_RELOCK);
    endfunction

    function automatic logic is_write(input state_t s);
        return (s == ST_WR_MODE) || (s == ST_WR_K) || (s == ST_WR_START);
    endfunction

endpackage

// File: rtl/pll_mode_switch_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_mode_switch.sv
// Retunes the system PLL between NTSC and PAL by rewriting fractional M through the
// reconfiguration controller, then follows lock until the new frequency is stable.
module pll_mode_switch
    import pll_cfg_pkg::*;
#(
    parameter logic [31:0] K_NTSC       = K_NTSC_DEF,
    parameter logic [31:0] K_PAL        = K_PAL_DEF,
    parameter int          LOCK_TIMEOUT = 2_000_000,
    parameter int          TW           = 21
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        pal,
    input  logic        locked,
    input  logic        mgmt_waitrequest,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    output logic        busy,
    output logic        cur_pal,
    output logic        err
);
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);

    state_t        state, state_nxt;
    logic          pal_s, lock_s;
    logic          target;
    logic          accept, timeout;
    logic [TW-1:0] tmo_cnt;
    logic [5:0]    wr_addr;
    logic [31:0]   wr_data;

    sync2 u_sync_pal  (.clk(refclk), .rst_n(rst_n), .d(pal),    .q(pal_s));
    sync2 u_sync_lock (.clk(refclk), .rst_n(rst_n), .d(locked), .q(lock_s));

    assign accept  = mgmt_write && !mgmt_waitrequest;
    assign timeout = (tmo_cnt == TMO_LAST);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:        if (pal_s != cur_pal) state_nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK:   if (lock_s) state_nxt = ST_WR_MODE;
                            else if (timeout) state_nxt = ST_IDLE;
            ST_WR_MODE:     if (accept) state_nxt = ST_WR_K;
            ST_WR_K:        if (accept) state_nxt = ST_WR_START;
            ST_WR_START:    if (accept) state_nxt = ST_WAIT_UNLOCK;
            // A small retune may never visibly drop lock, so a timeout here just moves on.
            ST_WAIT_UNLOCK: if (!lock_s || timeout) state_nxt = ST_WAIT_RELOCK;
            ST_WAIT_RELOCK: if (lock_s || timeout) state_nxt = ST_IDLE;
            default:        state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_addr = REG_MODE;
        wr_data = '0;
        case (state)
            ST_WR_K: begin
                wr_addr = REG_MFRAC;
                wr_data = target ? K_PAL : K_NTSC;
            end
            ST_WR_START: wr_addr = REG_START;
            default: ;
        endcase
    end

    // Any state change restarts the count, which clears it on entry to each wait state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state != state_nxt) begin
            tmo_cnt <= '0;
        end else if (is_wait(state) && !timeout) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            target  <= 1'b0;
            cur_pal <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (state == ST_IDLE && pal_s != cur_pal) target <= pal_s;
            if (state == ST_WAIT_LOCK && !lock_s && timeout) err <= 1'b1;
            // Once K is written the PLL runs at the new target whether or not it relocks.
            if (state == ST_WAIT_RELOCK) begin
                if (lock_s) begin
                    cur_pal <= target;
                    err     <= 1'b0;
                end else if (timeout) begin
                    cur_pal <= target;
                    err     <= 1'b1;
                end
            end
        end
    end

    // Write strobe is issued one cycle into each write state, giving an idle gap between writes.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
        end else if (is_write(state) && !mgmt_write) begin
            mgmt_write     <= 1'b1;
            mgmt_address   <= wr_addr;
            mgmt_writedata <= wr_data;
        end else if (accept) begin
            mgmt_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pll_mode_switch.sv
// Self-checking bench for pll_mode_switch: directed scenarios plus randomized switches
// compared against a transaction-level model of the expected register writes.
module tb_pll_mode_switch;
    import pll_cfg_pkg::*;

    localparam int          TO = 100;
    localparam logic [31:0] KP = 32'd2201376210;
    localparam logic [31:0] KN = 32'd2537930535;

    logic        refclk = 1'b0;
    logic        rst_n  = 1'b1;
    logic        pal    = 1'b0;
    logic        locked = 1'b1;
    logic        mgmt_waitrequest = 1'b0;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        busy, cur_pal, err;

    int nchecks = 0;
    int nerr = 0;
    int cyc = 0;
    int wr_mode = 0;
    int stall_cnt = 0;
    int stall_k = 0;
    int starts = 0;
    int start_edge = 0;
    int drop_dly = 3;
    int relock_dly = 50;
    bit pll_dead = 1'b0;
    logic m = 1'b0;
    logic merr = 1'b0;
    logic [37:0] acc_q[$];
    logic [37:0] exp_q[$];

    logic        pw = 1'b0, pq = 1'b0, pacc = 1'b0;
    logic [5:0]  pa = '0;
    logic [31:0] pd = '0;

    pll_mode_switch #(.LOCK_TIMEOUT(TO), .TW(21)) dut (
        .refclk(refclk),
        .rst_n(rst_n),
        .pal(pal),
        .locked(locked),
        .mgmt_waitrequest(mgmt_waitrequest),
        .mgmt_address(mgmt_address),
        .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata),
        .busy(busy),
        .cur_pal(cur_pal),
        .err(err)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge refclk);
        cyc++;
    end

    // Reconfig controller stall behaviour, selected by wr_mode.
    initial forever begin
        @(posedge refclk);
        #1;
        case (wr_mode)
            1: mgmt_waitrequest = ($urandom_range(0, 2) == 0);
            2: begin
                if (mgmt_write && mgmt_address == REG_MFRAC && stall_cnt < 5) begin
                    mgmt_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    mgmt_waitrequest = 1'b0;
                end
            end
            3: mgmt_waitrequest = mgmt_write && (mgmt_address == REG_MFRAC);
            default: mgmt_waitrequest = 1'b0;
        endcase
        if (wr_mode != 2) stall_cnt = 0;
    end

    // Bus monitor: records accepted writes and checks the hold / gap rules.
    initial forever begin
        @(negedge refclk);
        if (rst_n) begin
            if (pw && pq) begin
                chk("hold_write", 64'(mgmt_write), 64'(1));
                chk("hold_addr", 64'(mgmt_address), 64'(pa));
                chk("hold_data", 64'(mgmt_writedata), 64'(pd));
            end
            if (pacc) chk("gap_after_accept", 64'(mgmt_write), 64'(0));
            if (mgmt_write && mgmt_waitrequest && mgmt_address == REG_MFRAC) stall_k++;
            pacc = mgmt_write && !mgmt_waitrequest;
            if (pacc) begin
                acc_q.push_back({mgmt_address, mgmt_writedata});
                if (mgmt_address == REG_START) begin
                    starts++;
                    start_edge = cyc + 1;
                end
            end
            pw = mgmt_write;
            pq = mgmt_waitrequest;
            pa = mgmt_address;
            pd = mgmt_writedata;
        end else begin
            pw = 1'b0;
            pq = 1'b0;
            pacc = 1'b0;
        end
    end

    // PLL model: lock drops drop_dly cycles after a start write, returns relock_dly later.
    initial begin
        int handled;
        handled = 0;
        forever begin
            @(posedge refclk);
            if (starts != handled) begin
                handled = starts;
                repeat (drop_dly) @(posedge refclk);
                #1 locked = 1'b0;
                if (pll_dead) wait (!pll_dead);
                else repeat (relock_dly) @(posedge refclk);
                @(posedge refclk);
                #1 locked = 1'b1;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_busy(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge refclk);
            n++;
        end
        chk(tag, 64'(busy), 64'(lvl));
    endtask

    task automatic wait_start(input int s0, input string tag);
        int n;
        n = 0;
        while (starts == s0 && n < 400) begin
            @(negedge refclk);
            n++;
        end
        chk(tag, 64'(starts != s0), 64'(1));
    endtask

    task automatic push_seq(input logic t);
        exp_q.push_back({6'h00, 32'd0});
        exp_q.push_back({6'h07, t ? KP : KN});
        exp_q.push_back({6'h02, 32'd0});
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_nwrites"}, 64'(acc_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(acc_q[i]), 64'(exp_q[i]));
        acc_q.delete();
        exp_q.delete();
    endtask

    task automatic do_switch(input logic newpal, input string tag);
        pal = newpal;
        if (newpal != m) begin
            push_seq(newpal);
            wait_busy(1'b1, 10, {tag, "_start"});
            wait_busy(1'b0, 3000, {tag, "_done"});
            m = newpal;
            merr = 1'b0;
        end else begin
            repeat (8) @(negedge refclk);
            chk({tag, "_nobusy"}, 64'(busy), 64'(0));
        end
        chk_writes(tag);
        chk({tag, "_cur_pal"}, 64'(cur_pal), 64'(m));
        chk({tag, "_err"}, 64'(err), 64'(merr));
    endtask

    initial begin
        int s0;
        int tgt;
        int n;

        // Reset with pal = 0, locked = 1: nothing should happen.
        #2 rst_n = 1'b0;
        repeat (2) @(negedge refclk);
        chk("rst_write", 64'(mgmt_write), 64'(0));
        chk("rst_addr", 64'(mgmt_address), 64'(0));
        chk("rst_data", 64'(mgmt_writedata), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cur_pal", 64'(cur_pal), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge refclk);
            chk("quiet_write", 64'(mgmt_write), 64'(0));
            chk("quiet_busy", 64'(busy), 64'(0));
        end
        chk("quiet_cur_pal", 64'(cur_pal), 64'(0));

        // NTSC -> PAL, no stalls.
        drop_dly = 3;
        relock_dly = 50;
        do_switch(1'b1, "ntsc2pal");

        // Five-cycle stall on the K write.
        wr_mode = 2;
        stall_k = 0;
        do_switch(1'b0, "stall_k");
        chk("stall_k_cycles", 64'(stall_k), 64'(5));
        wr_mode = 0;

        // Request flips back during WAIT_RELOCK: last request wins.
        s0 = starts;
        pal = 1'b1;
        push_seq(1'b1);
        push_seq(1'b0);
        wait_busy(1'b1, 10, "mid_start");
        wait_start(s0, "mid_start_write");
        repeat (20) @(negedge refclk);
        pal = 1'b0;
        chk("mid_busy_relock", 64'(busy), 64'(1));
        wait_busy(1'b0, 500, "mid_first_done");
        chk("mid_first_cur_pal", 64'(cur_pal), 64'(1));
        wait_busy(1'b1, 10, "mid_second_start");
        wait_busy(1'b0, 3000, "mid_second_done");
        m = 1'b0;
        chk_writes("mid");
        chk("mid_cur_pal", 64'(cur_pal), 64'(0));
        chk("mid_err", 64'(err), 64'(0));

        // PLL never relocks: error at cycle TO of WAIT_RELOCK, target still applied.
        pll_dead = 1'b1;
        drop_dly = 3;
        s0 = starts;
        pal = 1'b1;
        push_seq(1'b1);
        wait_start(s0, "tmo_start_write");
        tgt = start_edge + drop_dly + 3 + TO - 1;
        while (cyc < tgt) @(negedge refclk);
        chk("tmo_busy_before", 64'(busy), 64'(1));
        chk("tmo_err_before", 64'(err), 64'(0));
        @(negedge refclk);
        chk("tmo_err", 64'(err), 64'(1));
        chk("tmo_busy_after", 64'(busy), 64'(0));
        chk("tmo_cur_pal", 64'(cur_pal), 64'(1));
        m = 1'b1;
        merr = 1'b1;
        chk_writes("tmo");
        pll_dead = 1'b0;
        repeat (10) @(negedge refclk);
        chk("err_sticky", 64'(err), 64'(1));
        chk("err_sticky_busy", 64'(busy), 64'(0));
        relock_dly = 30;
        do_switch(1'b0, "clear_err");

        // Randomized switches with random stalls and lock timing.
        wr_mode = 1;
        for (int i = 0; i < 6; i++) begin
            drop_dly = int'($urandom_range(1, 5));
            relock_dly = int'($urandom_range(10, 60));
            do_switch(1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end
        wr_mode = 0;
        @(negedge refclk);

        // Asynchronous reset while the K write is stalled.
        wr_mode = 3;
        pal = ~m;
        n = 0;
        while (!(mgmt_write && mgmt_address == REG_MFRAC) && n < 50) begin
            @(negedge refclk);
            n++;
        end
        chk("rst_reach_wr_k", 64'(mgmt_write && mgmt_address == REG_MFRAC), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_write", 64'(mgmt_write), 64'(0));
        chk("rst_async_busy", 64'(busy), 64'(0));
        chk("rst_async_cur_pal", 64'(cur_pal), 64'(0));
        wr_mode = 0;
        pal = 1'b1;
        acc_q.delete();
        exp_q.delete();
        m = 1'b0;
        merr = 1'b0;
        repeat (3) @(negedge refclk);
        rst_n = 1'b1;
        relock_dly = 40;
        drop_dly = 3;
        do_switch(1'b1, "after_rst");

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
